// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: datapath sizes and writeback source encodings
// used by the decoder, the EX/MEM and MEM/WB registers, and the writeback stage.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_SRC_ALU   = 2'b00,
    WB_SRC_MEM   = 2'b01,
    WB_SRC_PC4   = 2'b10,
    WB_SRC_PCIMM = 2'b11
  } wb_src_e;

endpackage

// File: rtl/rv_regfile.sv
// Integer register file with two combinational read ports; write lands at the next edge
// and is visible to readers in the same cycle through write-through bypass.
module rv_regfile
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;

  // x0 is never stored, so a write aimed at it neither updates nor bypasses.
  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_ok && raddr1 == waddr) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (wr_ok && raddr2 == waddr) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the W result, commits it once per instruction (0-cycle bypass,
// 1 edge to storage); wb_hold repeats are suppressed via the commit-once flag.
module wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_hold,
  input  logic              reg_writeW,
  input  logic [1:0]        reg_srcW,
  input  logic [XLEN-1:0]   lwd,
  input  logic [XLEN-1:0]   rlt_outW,
  input  logic [REG_AW-1:0] rd_outW,
  input  logic [XLEN-1:0]   pc_4W,
  input  logic [XLEN-1:0]   pc_immW,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [31:0]       wb_count
);

  logic        committed_q;
  logic [31:0] count_q;

  always_comb begin
    wb_data = rlt_outW;
    case (wb_src_e'(reg_srcW))
      WB_SRC_ALU:   wb_data = rlt_outW;
      WB_SRC_MEM:   wb_data = lwd;
      WB_SRC_PC4:   wb_data = pc_4W;
      WB_SRC_PCIMM: wb_data = pc_immW;
      default:      wb_data = rlt_outW;
    endcase
  end

  // A held cycle means the next W contents repeat this one, so the flag blocks re-commit.
  assign wb_we    = reg_writeW & (rd_outW != '0) & ~committed_q & ~rst;
  assign wb_rd    = rd_outW;
  assign wb_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      committed_q <= 1'b0;
      count_q     <= '0;
    end else begin
      committed_q <= wb_hold;
      if (wb_we) count_q <= count_q + 32'd1;
    end
  end

  rv_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (rd_outW),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expectations queued at drive time, popped and asserted
// when the DUT outputs are sampled mid-low-phase.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_hold;
  logic        reg_writeW;
  logic [1:0]  reg_srcW;
  logic [31:0] lwd, rlt_outW, pc_4W, pc_immW;
  logic [4:0]  rd_outW, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, wb_count;
  logic        wb_we;
  logic [4:0]  wb_rd;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .wb_hold    (wb_hold),
    .reg_writeW (reg_writeW),
    .reg_srcW   (reg_srcW),
    .lwd        (lwd),
    .rlt_outW   (rlt_outW),
    .rd_outW    (rd_outW),
    .pc_4W      (pc_4W),
    .pc_immW    (pc_immW),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] val, input logic hold);
    reg_writeW = we;
    reg_srcW   = src;
    rd_outW    = rd;
    rlt_outW   = val;
    wb_hold    = hold;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wb_hold = 1'b0; reg_writeW = 1'b0; reg_srcW = 2'b00;
    lwd = '0; rlt_outW = '0; rd_outW = '0; pc_4W = '0; pc_immW = '0;
    rs1_addr = '0; rs2_addr = '0;
    @(negedge clk);

    // Reset cycle with a would-be write: must be gated off.
    drive(1'b1, 2'b00, 5'd9, 32'h55, 1'b0);
    rs1_addr = 5'd9;
    push("we_during_reset", 32'd0);
    #1 chk(32'(wb_we));
    step();
    rst = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    push("count_after_reset", 32'd0);
    push("x9_after_reset", 32'd0);
    #1 chk(wb_count); chk(rs1_data);

    // Write x5 with same-cycle bypass, then read from storage.
    step();
    drive(1'b1, 2'b00, 5'd5, 32'h1234, 1'b0);
    rs1_addr = 5'd5;
    push("we_x5", 32'd1);
    push("wb_data_x5", 32'h1234);
    push("wb_rd_x5", 32'd5);
    push("bypass_x5", 32'h1234);
    #1 chk(32'(wb_we)); chk(wb_data); chk(32'(wb_rd)); chk(rs1_data);
    step();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    push("stored_x5", 32'h1234);
    push("count_x5", 32'd1);
    #1 chk(rs1_data); chk(wb_count);

    // Source mux: MEM, PC+4, PC+imm to x1..x3.
    lwd = 32'hAAAA0000; pc_4W = 32'h104; pc_immW = 32'h2000;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'(i), 5'(i), 32'hDEAD0000, 1'b0);
      case (i)
        1: push("mux_mem", 32'hAAAA0000);
        2: push("mux_pc4", 32'h104);
        default: push("mux_pcimm", 32'h2000);
      endcase
      #1 chk(wb_data);
      step();
    end
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    push("x1", 32'hAAAA0000);
    push("x2", 32'h104);
    #1 chk(rs1_data); chk(rs2_data);
    rs1_addr = 5'd3; rs2_addr = 5'd5;
    push("x3", 32'h2000);
    push("x5_kept", 32'h1234);
    push("count_mux", 32'd4);
    #1 chk(rs1_data); chk(rs2_data); chk(wb_count);

    // Both read ports bypass the same write.
    step();
    drive(1'b1, 2'b00, 5'd4, 32'hCAFE, 1'b0);
    rs1_addr = 5'd4; rs2_addr = 5'd4;
    push("dual_bypass_rs1", 32'hCAFE);
    push("dual_bypass_rs2", 32'hCAFE);
    #1 chk(rs1_data); chk(rs2_data);

    // x0 protection.
    step();
    drive(1'b1, 2'b00, 5'd0, 32'hFFFFFFFF, 1'b0);
    rs2_addr = 5'd0;
    push("we_x0", 32'd0);
    push("read_x0", 32'd0);
    #1 chk(32'(wb_we)); chk(rs2_data);
    step();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    push("count_x0", 32'd5);
    #1 chk(wb_count);

    // Stall: x7 held three cycles, then one more repeat cycle as hold drops.
    drive(1'b1, 2'b00, 5'd7, 32'h77, 1'b1);
    push("stall_we_c1", 32'd1);
    #1 chk(32'(wb_we));
    for (int c = 2; c <= 4; c++) begin
      step();
      if (c == 4) wb_hold = 1'b0;
      push("stall_we_repeat", 32'd0);
      #1 chk(32'(wb_we));
    end
    push("count_stall", 32'd6);
    #1 chk(wb_count);
    step();
    drive(1'b1, 2'b00, 5'd8, 32'h88, 1'b0);
    rs1_addr = 5'd7;
    push("we_x8", 32'd1);
    push("x7_stored", 32'h77);
    #1 chk(32'(wb_we)); chk(rs1_data);
    step();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    rs1_addr = 5'd8;
    push("x8_stored", 32'h88);
    push("count_x8", 32'd7);
    #1 chk(rs1_data); chk(wb_count);

    // Reset asserted mid-stall.
    drive(1'b1, 2'b00, 5'd9, 32'h99, 1'b1);
    #1;
    step();
    rst = 1'b1;
    push("we_reset_midstall", 32'd0);
    #1 chk(32'(wb_we));
    step();
    rst = 1'b0;
    drive(1'b1, 2'b00, 5'd10, 32'hA0, 1'b0);
    rs1_addr = 5'd9; rs2_addr = 5'd5;
    push("x9_cleared", 32'd0);
    push("x5_cleared", 32'd0);
    push("count_cleared", 32'd0);
    push("we_after_reset", 32'd1);
    #1 chk(rs1_data); chk(rs2_data); chk(wb_count); chk(32'(wb_we));
    step();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    push("count_post_reset", 32'd1);
    #1 chk(wb_count);

    // Counter wrap from preloaded all-ones.
    force dut.count_q = 32'hFFFFFFFF;
    #1 release dut.count_q;
    push("count_preload", 32'hFFFFFFFF);
    #1 chk(wb_count);
    drive(1'b1, 2'b00, 5'd11, 32'h1, 1'b0);
    step();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
    rs1_addr = 5'd11;
    push("count_wrap", 32'd0);
    push("x11_stored", 32'h1);
    #1 chk(wb_count); chk(rs1_data);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage RV32I pipeline: the consumer side of the MEM/WB pipeline register. Selects the writeback value from the four MEM/WB result fields, commits it to the 32×32 integer register file, and serves the decode stage's two combinational read ports with same-cycle write-through bypass. Each held instruction is committed exactly once across load-use stalls, and committed register writes are counted for performance monitoring.

## Interface
Parameters
- XLEN, 32, datapath width
- NREG, 32, architectural register count; x0 hardwired to zero

Ports
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wb_hold  in  1  same load-use hold that freezes MEM/WB; high means W contents are a repeat of the previous cycle
- reg_writeW  in  1  instruction in W writes rd
- reg_srcW  in  2  writeback source select
- lwd  in  XLEN  load data
- rlt_outW  in  XLEN  ALU result
- rd_outW  in  5  destination register
- pc_4W  in  XLEN  PC+4 (jal/jalr link)
- pc_immW  in  XLEN  PC+imm (auipc)
- rs1_addr, rs2_addr  in  5 each  decode-stage read addresses
- rs1_data, rs2_data  out  XLEN each  read data, bypassed
- wb_we  out  1  effective write strobe this cycle
- wb_rd  out  5  = rd_outW
- wb_data  out  XLEN  selected writeback value, to forwarding unit
- wb_count  out  32  committed-write counter

## Operation
- Source mux: 00 → rlt_outW, 01 → lwd, 10 → pc_4W, 11 → pc_immW. Pure combinational; wb_data always reflects the current W fields.
- Commit-once flag `committed` (1 bit):
  - Set at the edge where wb_hold=1.
  - Cleared at the edge where wb_hold=0.
  - Effect: an instruction is committed in the first cycle it occupies W; any following held cycles are repeats and do not re-commit.
- wb_we = reg_writeW & (rd_outW≠0) & ~committed & ~rst.
- Register file: on a rising edge with wb_we=1, regs[rd_outW] ← wb_data.
  - x0 is never stored and always reads 0.
  - Writes with rd=0 are dropped and not counted.
- Read ports: combinational.
  - rsN_addr=0 → 0.
  - else if wb_we & rsN_addr==rd_outW → wb_data (write-through bypass).
  - else regs[rsN_addr].
  - Both ports may bypass simultaneously.
- wb_count increments by 1 on each edge with wb_we=1 and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset, synchronous, takes effect at the edge where rst=1:
  - regs[1..31] = 0, committed = 0, wb_count = 0.
  - During a cycle with rst=1: wb_we=0, so no write and no count. rs1_data/rs2_data return reset-state contents after the edge.
- Reset asserted mid-stall: the flag clears. After reset, MEM/WB also holds zeros (reg_writeW=0), so no spurious commit.
- Write latency: 1 edge into storage; 0 cycles to a reader via bypass.
- wb_hold high for N consecutive cycles while one instruction sits in W: exactly 1 commit, in the first of those cycles if the instruction entered W that cycle.
- wb_hold rising in the same cycle a new instruction enters W: committed is still 0 from the prior non-hold edge, so the commit happens. The flag sets at that edge and blocks repeats.
- Simultaneous read/write of the same register: the reader gets the new value in the same cycle.
- wb_count and register write update on the same edge.

## Structure
- Shared package `rv_pkg`:
  - XLEN, NREG.
  - Source encodings WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_PC4=2'b10, WB_SRC_PCIMM=2'b11 (also used by the decoder and EX/MEM/MEM/WB stages).
- One sub-module `rv_regfile`:
  - Storage plus two bypassed read ports.
  - Inputs: we, waddr, wdata, raddr1/2.
  - Outputs: rdata1/2.
- The mux, commit-once flag and counter stay in wb_stage.

## Test plan
- Reset, then write x5: reg_writeW=1, src=00, rd=5, rlt_outW=0x1234 → wb_we=1 that cycle; rs1_addr=5 reads 0x1234 the same cycle via bypass and the next cycle from storage; wb_count=1.
- Source mux: src=01/10/11 with lwd=0xAAAA0000, pc_4W=0x104, pc_immW=0x2000 to rd=1/2/3 → x1=0xAAAA0000, x2=0x104, x3=0x2000.
- x0 protection: write 0xFFFFFFFF to rd=0 → wb_we=0, rs2_addr=0 reads 0, wb_count unchanged.
- Stall repeat: instruction to x7 held with wb_hold=1 for 3 cycles → one wb_we pulse; wb_count +1 only. Then hold drops with a new instruction to x8 → x8 written, count +1.
- Reset mid-stall: wb_hold=1, rst pulsed one cycle → all regs 0, wb_count=0, no write in the reset cycle.
- Counter wrap: preload wb_count to 0xFFFFFFFF via forced state, then one commit → wb_count=0.
